// File: rtl/pdp8_rfn.sv
// PDP-8 fixed-head disk controller: IOT decode, word-count/current-address DMA sequencing and disk strobes.
// Optional per-platter write protection is compiled in with `define RF_WRITE_LOCK_EN.
module pdp8_rfn #(
  parameter int         NUM_DISKS  = 4,
  parameter int         WORDS_LOG2 = 18,
  parameter logic [5:0] DEV_BASE   = 6'o60,
  parameter logic [3:0] IOT_STATE  = 4'd1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      iot,
  input  logic [3:0]                state,
  input  logic [11:0]               mb,
  input  logic [11:0]               io_data_in,
  output logic [11:0]               io_data_out,
  input  logic [5:0]                io_select,
  output logic                      io_data_avail,
  output logic                      io_skip,
  output logic                      io_interrupt,
  output logic                      dma_req,
  input  logic                      dma_ack,
  output logic [11:0]               dma_addr,
  output logic                      dma_wr,
  output logic [11:0]               dma_data_out,
  input  logic [11:0]               dma_data_in,
  output logic [3+WORDS_LOG2-1:0]   disk_addr,
  output logic                      disk_rd,
  output logic                      disk_wr,
  output logic [11:0]               disk_data_out,
  input  logic [11:0]               disk_data_in,
  input  logic                      disk_done
);

  localparam int DA_W = 3 + WORDS_LOG2;

  typedef enum logic [1:0] {IDLE, MEM, DISK, STEP} st_t;

  st_t              st_q, st_d;
  logic [11:0]      wc_q, wc_d, ca_q, ca_d, buf_q, buf_d;
  logic [DA_W-1:0]  da_q, da_d;
  logic             ie_q, ie_d, done_q, done_d, err_q, err_d;
  logic             nxd_q, nxd_d, wlk_q, wlk_d, rd_q, rd_d;
  logic [7:0]       lock_mask;

  function automatic logic [2:0] platter_of(input logic [DA_W-1:0] a);
    return a[DA_W-1 -: 3];
  endfunction

  function automatic logic bad_platter(input logic [2:0] p);
    return int'(p) >= NUM_DISKS;
  endfunction

  function automatic logic [DA_W-1:0] set_lo(input logic [DA_W-1:0] a, input logic [11:0] v);
    logic [23:0] t;
    t = 24'(a);
    t[11:0] = v;
    return t[DA_W-1:0];
  endfunction

  // AC[11] carries the interrupt enable, so only AC[10:0] can reach the high address bits.
  function automatic logic [DA_W-1:0] set_hi(input logic [DA_W-1:0] a, input logic [11:0] v);
    logic [23:0] t;
    t = 24'(a);
    t[23:12] = {1'b0, v[10:0]};
    return t[DA_W-1:0];
  endfunction

  logic [5:0]  dev_off;
  logic        fire, f0, f1, f2, f3;
  logic [2:0]  op;
  logic        busy;
  logic [11:0] status;
  logic        unused_mb;

  assign dev_off   = io_select - DEV_BASE;
  assign fire      = reset && iot && (state == IOT_STATE) && (dev_off < 6'd4);
  assign f0        = fire && (dev_off[1:0] == 2'd0);
  assign f1        = fire && (dev_off[1:0] == 2'd1);
  assign f2        = fire && (dev_off[1:0] == 2'd2);
  assign f3        = fire && (dev_off[1:0] == 2'd3);
  assign op        = mb[2:0];
  assign unused_mb = &{1'b0, mb[11:3]};

`ifdef RF_WRITE_LOCK_EN
  logic [7:0] lock_q, lock_d;

  always_comb begin
    lock_d = lock_q;
    if (f3 && op[0] && io_data_in[11]) lock_d = io_data_in[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lock_q <= '0;
    else        lock_q <= lock_d;
  end

  assign lock_mask = lock_q;
`else
  assign lock_mask = 8'h00;
`endif

  always_comb begin
    st_d   = st_q;
    wc_d   = wc_q;
    ca_d   = ca_q;
    buf_d  = buf_q;
    da_d   = da_q;
    ie_d   = ie_q;
    done_d = done_q;
    err_d  = err_q;
    nxd_d  = nxd_q;
    wlk_d  = wlk_q;
    rd_d   = rd_q;

    unique case (st_q)
      MEM: if (dma_ack) begin
        if (!rd_q) buf_d = dma_data_in;
        st_d = rd_q ? STEP : DISK;
      end
      DISK: if (disk_done) begin
        if (rd_q) buf_d = disk_data_in;
        st_d = rd_q ? MEM : STEP;
      end
      STEP: begin
        ca_d = ca_q + 12'd1;
        da_d = da_q + DA_W'(1);
        wc_d = wc_q + 12'd1;
        if (wc_d == 12'd0) begin
          done_d = 1'b1;
          st_d   = IDLE;
        end else if (bad_platter(platter_of(da_d))) begin
          nxd_d = 1'b1;
          err_d = 1'b1;
          st_d  = IDLE;
        end else if (!rd_q && lock_mask[platter_of(da_d)]) begin
          wlk_d = 1'b1;
          err_d = 1'b1;
          st_d  = IDLE;
        end else begin
          st_d = rd_q ? DISK : MEM;
        end
      end
      default: ;
    endcase

    // Abort wins over a start in the same IOT; sub-status flags are cleared along with error.
    if (f0) begin
      if (op[0]) begin
        done_d = 1'b0;
        err_d  = 1'b0;
        nxd_d  = 1'b0;
        wlk_d  = 1'b0;
        st_d   = IDLE;
      end else if ((st_q == IDLE) && (op[1] || op[2])) begin
        rd_d = op[1];
        if (bad_platter(platter_of(da_q))) begin
          nxd_d = 1'b1;
          err_d = 1'b1;
        end else if (!op[1] && lock_mask[platter_of(da_q)]) begin
          wlk_d = 1'b1;
          err_d = 1'b1;
        end else begin
          st_d = op[1] ? DISK : MEM;
        end
      end
    end

    if (f1) begin
      if (op[0]) wc_d = io_data_in;
      if (op[1]) ca_d = io_data_in;
      if (op[2]) da_d = set_lo(da_q, io_data_in);
    end

    if (f2 && op[0]) begin
      da_d = set_hi(da_q, io_data_in);
      ie_d = io_data_in[11];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= IDLE;
      wc_q   <= '0;
      ca_q   <= '0;
      buf_q  <= '0;
      da_q   <= '0;
      ie_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      nxd_q  <= 1'b0;
      wlk_q  <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      wc_q   <= wc_d;
      ca_q   <= ca_d;
      buf_q  <= buf_d;
      da_q   <= da_d;
      ie_q   <= ie_d;
      done_q <= done_d;
      err_q  <= err_d;
      nxd_q  <= nxd_d;
      wlk_q  <= wlk_d;
      rd_q   <= rd_d;
    end
  end

  assign busy   = (st_q != IDLE);
  assign status = {done_q, err_q, busy, nxd_q, wlk_q, 4'b0000, platter_of(da_q)};

  assign io_data_avail = f3 && (op != 3'b000);
  assign io_data_out   = ((f3 && op[0]) ? status : 12'd0) |
                         ((f3 && op[1]) ? ca_q   : 12'd0) |
                         ((f3 && op[2]) ? wc_q   : 12'd0);
  assign io_skip       = f2 && ((op[1] && done_q) || (op[2] && err_q));
  assign io_interrupt  = ie_q && (done_q || err_q);

  assign dma_req       = (st_q == MEM);
  assign dma_addr      = dma_req ? ca_q : 12'd0;
  assign dma_wr        = dma_req && rd_q;
  assign dma_data_out  = dma_wr ? buf_q : 12'd0;
  assign disk_addr     = da_q;
  assign disk_rd       = (st_q == DISK) && rd_q;
  assign disk_wr       = (st_q == DISK) && !rd_q;
  assign disk_data_out = disk_wr ? buf_q : 12'd0;

endmodule
